// File: rtl/block_match_dispatch_ctrl_if.sv
// Engine-array bus: one start pulse per engine plus the job addresses and tag.
// The master side is the dispatch controller; the slave side is the engine array.
interface block_match_dispatch_ctrl_if #(
   parameter int N_ENG = 2
);
   logic [N_ENG-1:0]    eng_ready;
   logic [N_ENG-1:0]    eng_start;
   logic [16*N_ENG-1:0] eng_blk_addr_l;
   logic [16*N_ENG-1:0] eng_blk_addr_r;
   logic [16*N_ENG-1:0] eng_srch_addr;
   logic [16*N_ENG-1:0] eng_blk_index;

   modport master (
      input  eng_ready,
      output eng_start, eng_blk_addr_l, eng_blk_addr_r, eng_srch_addr, eng_blk_index
   );

   modport slave (
      output eng_ready,
      input  eng_start, eng_blk_addr_l, eng_blk_addr_r, eng_srch_addr, eng_blk_index
   );
endinterface

// File: rtl/block_match_dispatch_ctrl.sv
// Walks every block of a stereo third-frame and hands each one to the lowest free
// block-match engine, then waits for both disparity filters before advancing the image.
module block_match_dispatch_ctrl #(
   parameter int RD_PORT_W  = 8,
   parameter int THIRD_W    = 240,
   parameter int CENTER_W   = 304,
   parameter int THIRD_H    = 480,
   parameter int BLK_W      = 16,
   parameter int BLK_H      = 16,
   parameter int SRCH_W     = 64,
   parameter int SRCH_H     = 32,
   parameter int BLK_STEP_Y = 16,
   parameter int N_ENG      = 2,
   parameter int NUM_BUFS   = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [3:0]                      img_number_in,
   block_match_dispatch_ctrl_if.master     eng,
   input  logic [3:0]                      filt_cnt_l,
   input  logic [3:0]                      filt_cnt_r,
   output logic [1:0]                      bm_working_buf,
   output logic                            bm_idle,
   output logic                            frame_done
);

   localparam int FW       = THIRD_W / RD_PORT_W;
   localparam int CW       = CENTER_W / RD_PORT_W;
   localparam int BA       = BLK_W / RD_PORT_W;
   localparam int SA       = SRCH_W / RD_PORT_W;
   localparam int COLS     = THIRD_W / BLK_W + ((CENTER_W - THIRD_W) / BLK_W) / 2;
   localparam int ROWS     = (THIRD_H - BLK_H) / BLK_STEP_Y + 1;
   localparam int SRCH_PAD = CW * ((SRCH_H - BLK_H) / 2);

   localparam logic [15:0] SRCH_ROW_STEP = 16'(CW * BLK_STEP_Y);
   localparam logic [15:0] BLK_ROW_STEP  = 16'(FW * BLK_STEP_Y);
   localparam logic [15:0] COL_STEP      = 16'(BA);
   localparam logic [15:0] R_OFF         = 16'(SA - BA);
   localparam logic [5:0]  LAST_COL      = 6'(COLS - 1);
   localparam logic [5:0]  LAST_ROW      = 6'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, WAIT_FILTER} state_t;

   state_t           state, state_nxt;
   logic [3:0]       img_number, img_next;
   logic [1:0]       buf_idx;
   logic [5:0]       row, col;
   logic [15:0]      row_srch, row_blk, col_off;
   logic [15:0]      srch_base, blk_base;
   logic [15:0]      cur_srch, cur_blk_l, cur_blk_r, cur_index;
   logic [N_ENG-1:0] avail, grant, mask;
   logic             last_blk, frame_adv;

   logic [1:0]       mask_cnt   [N_ENG];
   logic [15:0]      hold_srch  [N_ENG];
   logic [15:0]      hold_blk_l [N_ENG];
   logic [15:0]      hold_blk_r [N_ENG];
   logic [15:0]      hold_index [N_ENG];

   assign buf_idx   = img_number[1:0] & 2'(NUM_BUFS - 1);
   assign img_next  = img_number + 4'd1;
   assign cur_srch  = row_srch + col_off;
   assign cur_blk_l = row_blk + col_off;
   assign cur_blk_r = cur_blk_l - R_OFF;
   assign cur_index = {img_number, row, col};
   assign last_blk  = (row == LAST_ROW) && (col == LAST_COL);

   // Buffer base addresses are a constant per buffer, so this is a small mux, not a multiplier.
   always_comb begin
      srch_base = 16'(0 - SRCH_PAD);
      blk_base  = '0;
      for (int i = 1; i < NUM_BUFS; i++) begin
         if (buf_idx == 2'(i)) begin
            srch_base = 16'(i * CW * THIRD_H - SRCH_PAD);
            blk_base  = 16'(i * FW * THIRD_H);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N_ENG; k++) mask[k] = (mask_cnt[k] != 2'd0);
   end

   assign avail = eng.eng_ready & ~mask;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      grant     = '0;
      frame_adv = 1'b0;
      unique case (state)
         IDLE:
            if (img_number_in != img_number && &eng.eng_ready) state_nxt = DISPATCH;
         DISPATCH: begin
            grant = avail & (~avail + N_ENG'(1));
            if (|grant && last_blk) state_nxt = DRAIN;
         end
         DRAIN:
            if (&eng.eng_ready && ~|mask) state_nxt = WAIT_FILTER;
         WAIT_FILTER:
            if (filt_cnt_l == img_next && filt_cnt_r == img_next) begin
               frame_adv = 1'b1;
               state_nxt = IDLE;
            end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         img_number <= '0;
         frame_done <= 1'b0;
         row        <= '0;
         col        <= '0;
         row_srch   <= '0;
         row_blk    <= '0;
         col_off    <= '0;
      end else begin
         state      <= state_nxt;
         frame_done <= frame_adv;
         if (frame_adv) img_number <= img_next;
         if (state == IDLE) begin
            row      <= '0;
            col      <= '0;
            col_off  <= '0;
            row_srch <= srch_base;
            row_blk  <= blk_base;
         end else if (|grant) begin
            if (col == LAST_COL) begin
               col      <= '0;
               col_off  <= '0;
               row      <= row + 6'd1;
               row_srch <= row_srch + SRCH_ROW_STEP;
               row_blk  <= row_blk + BLK_ROW_STEP;
            end else begin
               col      <= col + 6'd1;
               col_off  <= col_off + COL_STEP;
            end
         end
      end
   end

   // NOTE: these per-engine arrays are small register banks, not RAM, so they are reset like any flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < N_ENG; k++) begin
            mask_cnt[k]   <= '0;
            hold_srch[k]  <= '0;
            hold_blk_l[k] <= '0;
            hold_blk_r[k] <= '0;
            hold_index[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_ENG; k++) begin
            if (grant[k]) begin
               mask_cnt[k]   <= 2'd2;
               hold_srch[k]  <= cur_srch;
               hold_blk_l[k] <= cur_blk_l;
               hold_blk_r[k] <= cur_blk_r;
               hold_index[k] <= cur_index;
            end else if (mask_cnt[k] != 2'd0) begin
               mask_cnt[k]   <= mask_cnt[k] - 2'd1;
            end
         end
      end
   end

   // The granted engine sees its new job in the same cycle as its start pulse.
   always_comb begin
      eng.eng_start      = grant;
      eng.eng_srch_addr  = '0;
      eng.eng_blk_addr_l = '0;
      eng.eng_blk_addr_r = '0;
      eng.eng_blk_index  = '0;
      for (int k = 0; k < N_ENG; k++) begin
         eng.eng_srch_addr[16*k +: 16]  = grant[k] ? cur_srch  : hold_srch[k];
         eng.eng_blk_addr_l[16*k +: 16] = grant[k] ? cur_blk_l : hold_blk_l[k];
         eng.eng_blk_addr_r[16*k +: 16] = grant[k] ? cur_blk_r : hold_blk_r[k];
         eng.eng_blk_index[16*k +: 16]  = grant[k] ? cur_index : hold_index[k];
      end
   end

   assign bm_working_buf = buf_idx;
   assign bm_idle        = (state == IDLE) && &eng.eng_ready && ~|mask;

endmodule

// File: tb/tb_block_match_dispatch_ctrl.sv
// Randomised bench for block_match_dispatch_ctrl: engine models with random busy time,
// a job scoreboard fed from the address formulas, and frame/filter/reset sequencing.
module tb_block_match_dispatch_ctrl;

   localparam int N_ENG    = 2;
   localparam int NUM_BUFS = 2;
   localparam int FW       = 240 / 8;
   localparam int CW       = 304 / 8;
   localparam int BA       = 16 / 8;
   localparam int SA       = 64 / 8;
   localparam int STEP_Y   = 16;
   localparam int THIRD_H  = 480;
   localparam int COLS     = 240 / 16 + ((304 - 240) / 16) / 2;
   localparam int ROWS     = (480 - 16) / STEP_Y + 1;
   localparam int N_JOBS   = ROWS * COLS;

   typedef struct {
      logic [15:0] srch;
      logic [15:0] blk_l;
      logic [15:0] blk_r;
      logic [15:0] index;
   } job_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       img_number_in, filt_cnt_l, filt_cnt_r;
   logic [1:0]       bm_working_buf;
   logic             bm_idle, frame_done;
   logic [N_ENG-1:0] ready = '1;

   block_match_dispatch_ctrl_if #(.N_ENG(N_ENG)) eng_if ();
   assign eng_if.eng_ready = ready;

   block_match_dispatch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .img_number_in  (img_number_in),
      .eng            (eng_if),
      .filt_cnt_l     (filt_cnt_l),
      .filt_cnt_r     (filt_cnt_r),
      .bm_working_buf (bm_working_buf),
      .bm_idle        (bm_idle),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   int   done_cnt = 0;
   int   exp_img  = 0;
   job_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Job for block (r,c) of image img straight from the buffer-layout arithmetic.
   function automatic job_t model_job(input int img, input int r, input int c);
      job_t j;
      int   b, srch, blk_l;
      b       = img % NUM_BUFS;
      srch    = b * CW * THIRD_H + r * CW * STEP_Y + c * BA - CW * ((32 - 16) / 2);
      blk_l   = b * FW * THIRD_H + r * FW * STEP_Y + c * BA;
      j.srch  = 16'(srch);
      j.blk_l = 16'(blk_l);
      j.blk_r = 16'(blk_l - (SA - BA));
      j.index = {4'(img), 6'(r), 6'(c)};
      return j;
   endfunction

   always @(posedge clk) cycle++;

   // Engine models: ready drops one or two cycles after a start, then stays low 1..4 cycles.
   initial begin
      logic [N_ENG-1:0] seen;
      int lag  [N_ENG];
      int busy [N_ENG];
      for (int k = 0; k < N_ENG; k++) begin
         lag[k]  = 0;
         busy[k] = 0;
      end
      forever begin
         @(negedge clk);
         seen = eng_if.eng_start & {N_ENG{reset}};
         @(posedge clk);
         #1;
         for (int k = 0; k < N_ENG; k++) begin
            if (seen[k]) begin
               lag[k]  = $urandom_range(0, 1);
               busy[k] = $urandom_range(1, 4);
               if (lag[k] == 0) ready[k] = 1'b0;
            end else if (lag[k] > 0) begin
               lag[k]   = 0;
               ready[k] = 1'b0;
            end else if (busy[k] > 0) begin
               busy[k]--;
               if (busy[k] == 0) ready[k] = 1'b1;
            end
         end
      end
   end

   // Monitor: checks every start against the scoreboard and the lowest-free-engine rule.
   initial begin
      int          last_start [N_ENG];
      logic [63:0] last_out   [N_ENG];
      logic [63:0] cur;
      job_t        j;
      logic        lower_free, k_free;
      for (int k = 0; k < N_ENG; k++) begin
         last_start[k] = -100;
         last_out[k]   = '0;
      end
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("start_in_reset", 64'(eng_if.eng_start), 64'd0);
            check("done_in_reset", 64'(frame_done), 64'd0);
            for (int k = 0; k < N_ENG; k++) last_out[k] = '0;
         end else begin
            if (frame_done) done_cnt++;
            if (|eng_if.eng_start)
               check("one_start_per_cycle", 64'($countones(eng_if.eng_start)), 64'd1);
            for (int k = 0; k < N_ENG; k++) begin
               cur = {eng_if.eng_srch_addr[16*k +: 16], eng_if.eng_blk_addr_l[16*k +: 16],
                      eng_if.eng_blk_addr_r[16*k +: 16], eng_if.eng_blk_index[16*k +: 16]};
               if (eng_if.eng_start[k]) begin
                  k_free     = ready[k] && (cycle - last_start[k] >= 3);
                  lower_free = 1'b0;
                  for (int m = 0; m < k; m++)
                     if (ready[m] && (cycle - last_start[m] >= 3)) lower_free = 1'b1;
                  check("started_engine_free", 64'(k_free), 64'd1);
                  check("lowest_free_engine", 64'(lower_free), 64'd0);
                  check("job_expected", 64'(exp_q.size() > 0), 64'd1);
                  if (exp_q.size() > 0) begin
                     j = exp_q.pop_front();
                     check("srch_addr",  64'(cur[63:48]), 64'(j.srch));
                     check("blk_addr_l", 64'(cur[47:32]), 64'(j.blk_l));
                     check("blk_addr_r", 64'(cur[31:16]), 64'(j.blk_r));
                     check("blk_index",  64'(cur[15:0]),  64'(j.index));
                  end
                  last_start[k] = cycle;
                  last_out[k]   = cur;
               end else begin
                  check("outputs_hold", cur, last_out[k]);
               end
            end
         end
      end
   end

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic run_frame();
      int t;
      int done_base;
      done_base = done_cnt;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_q.push_back(model_job(exp_img, r, c));
      @(posedge clk);
      #2 img_number_in = 4'(exp_img + 1);
      t = 0;
      while (exp_q.size() != 0 && t < 20000) begin
         @(posedge clk);
         t++;
      end
      check("frame_jobs_dispatched", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (10) @(posedge clk);
      settle();
      check("no_done_before_filters", 64'(done_cnt), 64'(done_base));
      check("busy_before_filters", 64'(bm_idle), 64'd0);
      check("buf_during_frame", 64'(bm_working_buf), 64'(exp_img % NUM_BUFS));
      @(posedge clk);
      #2 filt_cnt_l = 4'(exp_img + 1);
      repeat (4) @(posedge clk);
      settle();
      check("done_waits_for_right_filter", 64'(done_cnt), 64'(done_base));
      @(posedge clk);
      #2 filt_cnt_r = 4'(exp_img + 1);
      t = 0;
      while (done_cnt == done_base && t < 20) begin
         settle();
         t++;
      end
      check("frame_done_pulse", 64'(done_cnt), 64'(done_base + 1));
      exp_img = (exp_img + 1) % 16;
      settle();
      check("frame_done_single", 64'(done_cnt), 64'(done_base + 1));
      check("buf_after_frame", 64'(bm_working_buf), 64'(exp_img % NUM_BUFS));
      check("idle_after_frame", 64'(bm_idle), 64'd1);
   endtask

   initial begin
      int t;
      reset         = 1'b0;
      img_number_in = '0;
      filt_cnt_l    = '0;
      filt_cnt_r    = '0;
      repeat (3) @(posedge clk);
      settle();
      check("reset_start", 64'(eng_if.eng_start), 64'd0);
      check("reset_buf", 64'(bm_working_buf), 64'd0);
      check("reset_idle", 64'(bm_idle), 64'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      settle();
      check("post_reset_idle", 64'(bm_idle), 64'd1);
      check("post_reset_srch0", 64'(eng_if.eng_srch_addr), 64'd0);

      // 17 frames carry the image number through 15 -> 0 with both filters gating each one.
      for (int f = 0; f < 17; f++) run_frame();

      // Reset in the middle of a frame, then a clean restart from block 0 of image 0.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) exp_q.push_back(model_job(exp_img, r, c));
      @(posedge clk);
      #2 img_number_in = 4'(exp_img + 1);
      t = 0;
      while (exp_q.size() > N_JOBS - 100 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("partial_frame_progress", 64'(exp_q.size() <= N_JOBS - 100), 64'd1);
      @(posedge clk);
      #2;
      reset         = 1'b0;
      img_number_in = '0;
      filt_cnt_l    = '0;
      filt_cnt_r    = '0;
      exp_q.delete();
      exp_img = 0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      t = 0;
      while (!(&ready) && t < 20) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      settle();
      check("idle_after_mid_reset", 64'(bm_idle), 64'd1);
      check("buf_after_mid_reset", 64'(bm_working_buf), 64'd0);
      check("no_start_after_mid_reset", 64'(eng_if.eng_start), 64'd0);
      run_frame();
      run_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cycle);
      $fatal(1, "timeout");
   end

endmodule
